uart_core_fifo_gen: RTL and testbench
=====================================

# uart_core_fifo_gen

Parametrised next-generation UART core for the APB UART wrapper. It has a 16x-oversampled receiver, a run-time selectable frame format (5–8 data bits, optional parity, 1 or 2 stop bits), and depth-parametrised TX and RX FIFOs. Each RX FIFO entry stores its own parity and framing error flags next to the data byte. It drops into the same place as the existing UART core: behind the register-interface strobes, driving the TX/RX pins.

## Interface
Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, ≥2
- RX_DEPTH, 16, RX FIFO entries; power of 2, ≥2
- BAUD_WIDTH, 13, width of BAUD_VAL

Ports:
- CLK  in  1  system clock; the only clock
- RESET_N  in  1  reset; synchronous, active-low
- CSN  in  1  chip select, active-low
- WEN  in  1  write strobe, active-low; a write cycle is CSN=0 & WEN=0
- OEN  in  1  read strobe, active-low; a read cycle is CSN=0 & OEN=0
- DATA_IN  in  8  TX byte
- DATA_OUT  out  8  RX FIFO head byte; 0 when the RX FIFO is empty
- BAUD_VAL  in  BAUD_WIDTH  oversample tick period minus 1
- DATA_BITS  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8
- PARITY_EN  in  1  parity bit present
- ODD_N_EVEN  in  1  1=odd parity, 0=even parity
- STOP2  in  1  transmit 2 stop bits
- RX  in  1  serial input, asynchronous
- TX  out  1  serial output
- TXRDY  out  1  TX FIFO not full
- TX_EMPTY  out  1  TX FIFO empty and TX FSM in IDLE
- RXRDY  out  1  RX FIFO not empty
- PARITY_ERR  out  1  parity error flag of the head entry
- FRAMING_ERR  out  1  framing error flag of the head entry
- OVERFLOW  out  1  sticky flag: a received frame was dropped
- TX_LEVEL  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- RX_LEVEL  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy

## Operation
Baud generator:
- Free-running counter runs 0..BAUD_VAL, then wraps to 0.
- `tick` is high for one cycle when counter==BAUD_VAL. Tick period is BAUD_VAL+1 clocks; BAUD_VAL=0 gives a tick every cycle.
- One bit period = 16 ticks.

TX path:
- A write cycle pushes DATA_IN into the TX FIFO. A write while full is ignored and the FIFO is unchanged.
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE.
- IDLE exit: on a tick cycle with the FIFO non-empty, pop the FIFO, load the shifter, enter START. TX drives 0 from the next cycle.
- Each state lasts exactly 16 ticks.
- DATA sends DATA_BITS+5 bits, LSB first.
- Parity bit = XOR of the sent data bits; inverted when ODD_N_EVEN=1.
- Stop bits are 1. STOP2 adds the second stop state.
- Back-to-back frames: STOP exit goes straight to START if the FIFO is non-empty. No idle gap.

RX path:
- RX passes through a 2-flop synchroniser; both flops reset to 1.
- RX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: on synchronised RX=0, clear the tick counter and enter START.
- START: at tick 8, if RX=1 treat it as a glitch and return to IDLE. Otherwise enter DATA.
- Every later bit is sampled 16 ticks after the previous sample (mid-bit).
- Data is shifted in LSB first; unused upper bits are 0.
- Parity error = received parity ≠ computed parity.
- Only one stop bit is checked. Framing error = stop sample is 0.
- On the cycle after the stop sample, push {framing_err, parity_err, byte} into the RX FIFO (10-bit entries), then go to IDLE.
- Errored frames are stored, not dropped.

Read and status:
- A read cycle pops the RX FIFO when it is non-empty. A read when empty has no effect.
- DATA_OUT, PARITY_ERR and FRAMING_ERR show the head entry (first-word fall-through).
- A push while the RX FIFO is full is dropped, even if a pop happens the same cycle, and OVERFLOW is set.
- OVERFLOW is cleared by a read cycle. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values:
  - TX=1, TXRDY=1, TX_EMPTY=1.
  - RXRDY=0, DATA_OUT=0, PARITY_ERR=0, FRAMING_ERR=0, OVERFLOW=0.
  - Both levels 0, both FSMs in IDLE, baud counter 0.
- Reset asserted mid-frame: all state returns to reset values on the next CLK edge; FIFO contents are discarded.
- FIFO push and pop take effect on the clock edge.
- TXRDY, RXRDY and the levels are registered and reflect the FIFO state from the cycle after the edge.
- Write to TX falling edge: TX FIFO non-empty 1 cycle after the write, then TX falls 1 cycle after the next tick.
- RX latency: RXRDY goes high 2 cycles after the stop-bit sample tick (push cycle, then the registered flag).
- Simultaneous push and pop on a non-full, non-empty FIFO: level is unchanged and data order is preserved.
- Pointers wrap modulo depth.
- Changing config (format or BAUD_VAL) mid-frame corrupts only that frame. Both FSMs must return to IDLE within one frame time.

## Test plan
- BAUD_VAL=3, 8N1, write 0xA5. TX shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 64 cycles wide. TX_EMPTY returns to 1 after the stop bit.
- Loop TX→RX, 7 data bits, odd parity, 2 stop bits, send 0x00, 0x7F, 0x55 back-to-back. Reads return the same bytes with PARITY_ERR=0 and no idle gap on TX.
- Drive an RX frame with wrong parity, then one with stop=0. First read shows PARITY_ERR=1 with its byte; second read shows FRAMING_ERR=1; both flags then clear.
- With RX_DEPTH=4, receive 5 frames without reading. RX_LEVEL=4 and OVERFLOW=1; the 5th byte is lost; one read clears OVERFLOW and returns the first byte.
- Pulse RX low for 5 ticks. No entry is pushed and RXRDY stays 0.
- Assert RESET_N=0 for 1 cycle mid-TX frame. TX=1 and TX_LEVEL=0 on the next cycle; a new write transmits normally.

Source files
------------

// File: rtl/uart_core_fifo_gen_if.sv
// uart_core_fifo_gen_if: register-strobe bus between the APB wrapper and the UART core
interface uart_core_fifo_gen_if;
    logic       CSN;
    logic       WEN;
    logic       OEN;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       TXRDY;
    logic       TX_EMPTY;
    logic       RXRDY;
    logic       PARITY_ERR;
    logic       FRAMING_ERR;
    logic       OVERFLOW;
    modport master (
        output CSN, WEN, OEN, DATA_IN,
        input  DATA_OUT, TXRDY, TX_EMPTY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW
    );
    modport slave (
        input  CSN, WEN, OEN, DATA_IN,
        output DATA_OUT, TXRDY, TX_EMPTY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW
    );
endinterface

// File: rtl/uart_core_fifo_gen.sv
// uart_core_fifo_gen: 16x-oversampled UART core with run-time frame format and
// depth-parametrised TX/RX FIFOs; each RX entry carries its own error flags.
module uart_core_fifo_gen #(
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int BAUD_WIDTH = 13
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    uart_core_fifo_gen_if.slave       bus,
    input  logic [BAUD_WIDTH-1:0]     BAUD_VAL,
    input  logic [1:0]                DATA_BITS,
    input  logic                      PARITY_EN,
    input  logic                      ODD_N_EVEN,
    input  logic                      STOP2,
    input  logic                      RX,
    output logic                      TX,
    output logic [$clog2(TX_DEPTH):0] TX_LEVEL,
    output logic [$clog2(RX_DEPTH):0] RX_LEVEL
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_PUSH} rx_state_t;

    logic [BAUD_WIDTH-1:0] baud_cnt;
    logic                  tick;
    logic [2:0]            last_bit;
    logic [7:0]            data_mask;

    // >= lets the counter recover at once if BAUD_VAL is lowered mid-count
    assign tick      = baud_cnt >= BAUD_VAL;
    assign last_bit  = {1'b0, DATA_BITS} + 3'd4;
    assign data_mask = 8'hFF >> ~DATA_BITS;

    always_ff @(posedge CLK)
        if (!RESET_N || tick) baud_cnt <= '0;
        else baud_cnt <= baud_cnt + 1'b1;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic           tx_push, tx_pop, tx_bit_end, tx_end;
    tx_state_t      tx_st;
    logic [3:0]     tx_cnt;
    logic [2:0]     tx_bit;
    logic [7:0]     tx_sh;
    logic           tx_par;

    assign tx_push    = !bus.CSN && !bus.WEN && TX_LEVEL != TX_FULL;
    assign tx_bit_end = tick && tx_cnt == 4'd15;
    assign tx_end     = tx_bit_end && (tx_st == T_STOP2 || (tx_st == T_STOP1 && !STOP2));
    assign tx_pop     = TX_LEVEL != '0 && (tx_end || (tx_st == T_IDLE && tick));

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= bus.DATA_IN;
        if (!RESET_N) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            TX_LEVEL <= '0;
        end else begin
            tx_wp    <= tx_wp + TAW'(tx_push);
            tx_rp    <= tx_rp + TAW'(tx_pop);
            TX_LEVEL <= TX_LEVEL + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        end
    end

    // Loading straight from a stop bit gives back-to-back frames with no idle gap
    always_ff @(posedge CLK)
        if (!RESET_N) begin
            tx_st  <= T_IDLE;
            TX     <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else if (tx_pop) begin
            tx_st  <= T_START;
            TX     <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= tx_mem[tx_rp];
            tx_par <= ^(tx_mem[tx_rp] & data_mask) ^ ODD_N_EVEN;
        end else if (tx_st != T_IDLE && tick) begin
            tx_cnt <= tx_cnt + 1'b1;
            if (tx_cnt == 4'd15)
                case (tx_st)
                    T_START: begin
                        tx_st <= T_DATA;
                        TX    <= tx_sh[0];
                    end
                    T_DATA:
                        if (tx_bit == last_bit) begin
                            tx_st <= PARITY_EN ? T_PAR : T_STOP1;
                            TX    <= PARITY_EN ? tx_par : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            tx_sh  <= tx_sh >> 1;
                            TX     <= tx_sh[1];
                        end
                    T_PAR: begin
                        tx_st <= T_STOP1;
                        TX    <= 1'b1;
                    end
                    T_STOP1: tx_st <= STOP2 ? T_STOP2 : T_IDLE;
                    default: tx_st <= T_IDLE;
                endcase
        end

    assign bus.TXRDY    = TX_LEVEL != TX_FULL;
    assign bus.TX_EMPTY = TX_LEVEL == '0 && tx_st == T_IDLE;

    logic [1:0] rx_sync;
    logic       rxs, rx_sample;
    rx_state_t  rx_st;
    logic [3:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_byte;
    logic       rx_perr, rx_ferr;

    assign rxs       = rx_sync[1];
    assign rx_sample = tick && rx_cnt == (rx_st == R_START ? 4'd7 : 4'd15);

    always_ff @(posedge CLK)
        if (!RESET_N) rx_sync <= 2'b11;
        else rx_sync <= {rx_sync[0], RX};

    always_ff @(posedge CLK)
        if (!RESET_N) begin
            rx_st   <= R_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_byte <= '0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
        end else
            case (rx_st)
                R_IDLE:
                    if (!rxs) begin
                        rx_st   <= R_START;
                        rx_cnt  <= '0;
                        rx_bit  <= '0;
                        rx_byte <= '0;
                        rx_perr <= 1'b0;
                        rx_ferr <= 1'b0;
                    end
                R_PUSH: rx_st <= R_IDLE;
                default:
                    if (tick) begin
                        rx_cnt <= rx_sample ? 4'd0 : rx_cnt + 1'b1;
                        if (rx_sample)
                            case (rx_st)
                                R_START: rx_st <= rxs ? R_IDLE : R_DATA;
                                R_DATA: begin
                                    rx_byte[rx_bit] <= rxs;
                                    rx_bit          <= rx_bit + 1'b1;
                                    if (rx_bit == last_bit) rx_st <= PARITY_EN ? R_PAR : R_STOP;
                                end
                                R_PAR: begin
                                    rx_perr <= rxs != (^rx_byte ^ ODD_N_EVEN);
                                    rx_st   <= R_STOP;
                                end
                                default: begin
                                    rx_ferr <= !rxs;
                                    rx_st   <= R_PUSH;
                                end
                            endcase
                    end
            endcase

    logic [9:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic           rd_cyc, rx_full, rx_ne, rx_push, rx_pop;
    logic [9:0]     rx_head;

    assign rd_cyc  = !bus.CSN && !bus.OEN;
    assign rx_full = RX_LEVEL == RX_FULL;
    assign rx_ne   = RX_LEVEL != '0;
    assign rx_push = rx_st == R_PUSH && !rx_full;
    assign rx_pop  = rd_cyc && rx_ne;
    assign rx_head = rx_ne ? rx_mem[rx_rp] : 10'd0;

    // A push into a full FIFO is dropped even when a pop frees a slot that cycle
    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wp] <= {rx_ferr, rx_perr, rx_byte};
        if (!RESET_N) begin
            rx_wp        <= '0;
            rx_rp        <= '0;
            RX_LEVEL     <= '0;
            bus.OVERFLOW <= 1'b0;
        end else begin
            rx_wp        <= rx_wp + RAW'(rx_push);
            rx_rp        <= rx_rp + RAW'(rx_pop);
            RX_LEVEL     <= RX_LEVEL + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            bus.OVERFLOW <= (rx_st == R_PUSH && rx_full) || (bus.OVERFLOW && !rd_cyc);
        end
    end

    assign bus.RXRDY       = rx_ne;
    assign bus.DATA_OUT    = rx_head[7:0];
    assign bus.PARITY_ERR  = rx_head[8];
    assign bus.FRAMING_ERR = rx_head[9];
endmodule

// File: tb/tb_uart_core_fifo_gen.sv
// tb_uart_core_fifo_gen: scoreboarded bench; TX frames and RX FIFO entries are
// predicted from the frame rules and checked by independent monitor processes.
module tb_uart_core_fifo_gen;
    localparam int TXD = 8;
    localparam int RXD = 4;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic [12:0] baud = 13'd3;
    logic [1:0] dbits = 2'd3;
    logic pen = 1'b0, odd = 1'b0, stop2 = 1'b0;
    logic rx_drv = 1'b1, loop = 1'b0;
    logic wr_csn = 1'b1, wr_wen = 1'b1, rd_csn = 1'b1, rd_oen = 1'b1, man_rd = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic TX, RX;
    logic [$clog2(TXD):0] tx_level;
    logic [$clog2(RXD):0] rx_level;
    int compared = 0, mismatched = 0, cyc = 0;
    logic auto_read = 1'b0, tx_abort = 1'b0, tx_busy = 1'b0;
    logic [9:0] rxq[$];
    logic [11:0] txq_bits[$];
    int txq_len[$];
    int tx_starts[$];

    uart_core_fifo_gen_if bus();
    assign bus.CSN     = wr_csn & rd_csn & ~man_rd;
    assign bus.WEN     = wr_wen;
    assign bus.OEN     = rd_oen & ~man_rd;
    assign bus.DATA_IN = wdata;
    assign RX          = loop ? TX : rx_drv;

    uart_core_fifo_gen #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .BAUD_WIDTH(13)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus), .BAUD_VAL(baud), .DATA_BITS(dbits),
        .PARITY_EN(pen), .ODD_N_EVEN(odd), .STOP2(stop2), .RX(RX), .TX(TX),
        .TX_LEVEL(tx_level), .RX_LEVEL(rx_level)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-level frame: start, data LSB first, parity from a ones count, stop bits
    function automatic int frame_bits(input logic [7:0] b, output logic [11:0] bits);
        int nd, ones;
        nd = int'(dbits) + 5;
        ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            bits[1 + i] = b[i];
            ones += int'(b[i]);
        end
        if (pen) bits[1 + nd] = ((ones + int'(odd)) % 2) == 1;
        return 2 + nd + int'(pen) + int'(stop2);
    endfunction

    function automatic logic [7:0] masked(input logic [7:0] b);
        return 8'(int'(b) % (1 << (int'(dbits) + 5)));
    endfunction

    task automatic write_byte(input logic [7:0] b);
        logic [11:0] bits;
        int n;
        n = frame_bits(b, bits);
        txq_bits.push_back(bits);
        txq_len.push_back(n);
        @(negedge CLK);
        wdata = b; wr_csn = 1'b0; wr_wen = 1'b0;
        @(negedge CLK);
        wr_csn = 1'b1; wr_wen = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit expect_it);
        logic [11:0] bits;
        int n, p, sidx;
        n = frame_bits(b, bits);
        p = 16 * (int'(baud) + 1);
        sidx = 1 + int'(dbits) + 5 + int'(pen);
        if (pen && bad_par) bits[sidx - 1] = ~bits[sidx - 1];
        if (expect_it) rxq.push_back({bad_stop, pen & bad_par, masked(b)});
        @(negedge CLK);
        for (int i = 0; i < sidx; i++) begin
            rx_drv = bits[i];
            repeat (p) @(negedge CLK);
        end
        if (bad_stop) begin
            rx_drv = 1'b0;
            repeat (10 * (int'(baud) + 1)) @(negedge CLK);
        end
        rx_drv = 1'b1;
        repeat (2 * p) @(negedge CLK);
    endtask

    task automatic drain(input string name, input int budget);
        int t;
        t = 0;
        while (t < budget && !(txq_len.size() == 0 && !tx_busy && rxq.size() == 0 && bus.TX_EMPTY)) begin
            @(negedge CLK);
            t++;
        end
        check(name, 32'(t < budget), 1);
        repeat (5) @(negedge CLK);
    endtask

    initial begin : tx_mon
        logic [11:0] bits;
        int n, p, bad;
        bit aborted;
        forever begin
            @(negedge CLK);
            if (RESET_N && TX === 1'b0) begin
                if (txq_len.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL tx_unexpected_frame: TX fell at cycle %0d with no frame queued", cyc);
                    while (TX === 1'b0) @(negedge CLK);
                end else begin
                    bits = txq_bits.pop_front();
                    n = txq_len.pop_front();
                    tx_busy = 1'b1;
                    tx_starts.push_back(cyc);
                    p = 16 * (int'(baud) + 1);
                    aborted = 0;
                    for (int i = 0; i < n && !aborted; i++) begin
                        bad = 0;
                        for (int j = 0; j < p; j++) begin
                            if (i > 0 || j > 0) @(negedge CLK);
                            if (tx_abort) begin
                                aborted = 1;
                                break;
                            end
                            if (TX !== bits[i]) bad++;
                        end
                        if (!aborted) check($sformatf("tx_bit%0d_bad_cycles", i), 32'(bad), 0);
                    end
                    tx_abort = 1'b0;
                    tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin : rx_mon
        forever begin
            @(negedge CLK);
            if (auto_read && bus.RXRDY) begin
                if (rxq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rx_unexpected_entry: got %0h with nothing expected",
                             {bus.FRAMING_ERR, bus.PARITY_ERR, bus.DATA_OUT});
                end else
                    check("rx_entry", 32'({bus.FRAMING_ERR, bus.PARITY_ERR, bus.DATA_OUT}), 32'(rxq.pop_front()));
                rd_csn = 1'b0; rd_oen = 1'b0;
                @(negedge CLK);
                rd_csn = 1'b1; rd_oen = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (compared %0d)", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ob[5];
        logic [7:0] b;
        int nb, flen;
        repeat (3) @(negedge CLK);
        check("rst_TX", 32'(TX), 1);
        check("rst_TXRDY", 32'(bus.TXRDY), 1);
        check("rst_TX_EMPTY", 32'(bus.TX_EMPTY), 1);
        check("rst_RXRDY", 32'(bus.RXRDY), 0);
        check("rst_DATA_OUT", 32'(bus.DATA_OUT), 0);
        check("rst_flags", 32'({bus.PARITY_ERR, bus.FRAMING_ERR, bus.OVERFLOW}), 0);
        check("rst_levels", 32'({tx_level, rx_level}), 0);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        // 8N1 single frame
        write_byte(8'hA5);
        drain("t1_drain", 2000);
        check("t1_TX_EMPTY", 32'(bus.TX_EMPTY), 1);
        check("t1_frames", 32'(tx_starts.size()), 1);

        // Loopback 7O2 back-to-back
        dbits = 2'd2; pen = 1'b1; odd = 1'b1; stop2 = 1'b1; loop = 1'b1; auto_read = 1'b1;
        tx_starts.delete();
        foreach (ob[i]) ob[i] = 8'd0;
        ob[1] = 8'h7F; ob[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            rxq.push_back({2'b00, ob[i]});
            write_byte(ob[i]);
        end
        drain("t2_drain", 4000);
        check("t2_frames", 32'(tx_starts.size()), 3);
        if (tx_starts.size() == 3) begin
            check("t2_gap01", 32'(tx_starts[1] - tx_starts[0]), 11 * 64);
            check("t2_gap12", 32'(tx_starts[2] - tx_starts[1]), 11 * 64);
        end
        loop = 1'b0;

        // Parity error then framing error, 8E1
        dbits = 2'd3; pen = 1'b1; odd = 1'b0; stop2 = 1'b0;
        send_rx(8'h3C, 1, 0, 1);
        send_rx(8'hC3, 0, 1, 1);
        drain("t3_drain", 2000);
        check("t3_flags_clear", 32'({bus.PARITY_ERR, bus.FRAMING_ERR, bus.RXRDY}), 0);

        // Overflow with 5 frames into a 4-deep RX FIFO
        pen = 1'b0; auto_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ob[i] = 8'($urandom);
            send_rx(ob[i], 0, 0, 0);
        end
        repeat (10) @(negedge CLK);
        check("t4_RX_LEVEL_full", 32'(rx_level), 4);
        check("t4_OVERFLOW_set", 32'(bus.OVERFLOW), 1);
        check("t4_head", 32'(bus.DATA_OUT), 32'(ob[0]));
        man_rd = 1'b1;
        @(negedge CLK);
        man_rd = 1'b0;
        check("t4_OVERFLOW_clr", 32'(bus.OVERFLOW), 0);
        check("t4_RX_LEVEL_after_read", 32'(rx_level), 3);
        for (int i = 1; i < 4; i++) rxq.push_back({2'b00, ob[i]});
        auto_read = 1'b1;
        drain("t4_drain", 500);
        check("t4_RX_LEVEL_empty", 32'(rx_level), 0);

        // 5-tick glitch on RX
        rx_drv = 1'b0;
        repeat (5 * (int'(baud) + 1)) @(negedge CLK);
        rx_drv = 1'b1;
        repeat (40 * (int'(baud) + 1)) @(negedge CLK);
        check("t5_RXRDY", 32'(bus.RXRDY), 0);
        check("t5_RX_LEVEL", 32'(rx_level), 0);

        // Reset in the middle of a TX frame
        write_byte(8'h96);
        repeat (150) @(negedge CLK);
        tx_abort = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        check("t6_TX", 32'(TX), 1);
        check("t6_TX_LEVEL", 32'(tx_level), 0);
        check("t6_TX_EMPTY", 32'(bus.TX_EMPTY), 1);
        write_byte(8'h3C);
        drain("t6_drain", 2000);

        // Random formats in loopback
        loop = 1'b1;
        for (int it = 0; it < 4; it++) begin
            baud = 13'($urandom_range(0, 3));
            dbits = 2'($urandom_range(0, 3));
            pen = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            stop2 = 1'($urandom_range(0, 1));
            nb = $urandom_range(2, 4);
            flen = 16 * (int'(baud) + 1) * 12;
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                rxq.push_back({2'b00, masked(b)});
                write_byte(b);
            end
            drain($sformatf("t7_drain%0d", it), nb * flen + 500);
        end
        loop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
